branch_target_predictor: RTL and testbench

// - Next-PC predictor for the fetch stage; produces the value loaded into the program counter.
// - Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
// - Lookup on the current fetch PC is combinational (same cycle).
// - Table updates come from the EX-stage branch resolution; they are registered and visible to lookups from the next cycle.
// - Also keeps lookup-hit and mispredict performance counters.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/sat_counter2.sv | 21 ++
 rtl/branch_target_predictor.sv | 96 +++++++++
 tb/tb_branch_target_predictor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: BTB geometry, counter encodings and entry layout.
package cpu_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TAG_W   = PC_W - IDX_W - 2;
    localparam int unsigned CNT_W   = 32;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;
    localparam logic [1:0]      CTR_WNT = 2'b01;
    localparam logic [1:0]      CTR_WT  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state logic (combinational).
// Ports:
//   ctr_i      current counter value
//   inc_i      1 = count up, 0 = count down
//   ctr_next_c next counter value, saturating at 2'b11 and 2'b00
module sat_counter2 (
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_next_c
);

    always_comb begin
        ctr_next_c = ctr_i;
        if (inc_i) begin
            if (ctr_i != 2'b11) ctr_next_c = ctr_i + 2'b01;
        end else begin
            if (ctr_i != 2'b00) ctr_next_c = ctr_i - 2'b01;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit direction counters,
// combinational lookup, registered update from EX, hit/mispredict counters.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   pc_i                 current fetch PC
//   pred_pc_o            predicted next PC (combinational from pc_i)
//   pred_taken_o         1 = BTB hit with counter in a taken state
//   upd_valid_i          resolved branch this cycle
//   upd_pc_i             PC of resolved branch
//   upd_taken_i          actual direction
//   upd_target_i         actual target
//   upd_mispred_i        EX reports a misprediction
//   hit_cnt_o            lookup-hit cycle count
//   mispred_cnt_o        misprediction count
module branch_target_predictor
    import cpu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PC_W-1:0]  pc_i,
    output logic [PC_W-1:0]  pred_pc_o,
    output logic             pred_taken_o,
    input  logic             upd_valid_i,
    input  logic [PC_W-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [PC_W-1:0]  upd_target_i,
    input  logic             upd_mispred_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    btb_entry_t       table_q [ENTRIES];
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_entry;
    logic             lk_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    logic [1:0]       upd_ctr_next;

    // Byte-offset bits and the lookup counter's low bit carry no information here.
    logic             ofs_unused;
    assign ofs_unused = ^{upd_pc_i[1:0], lk_entry.ctr[0]};

    // Lookup: reads pre-update table contents, so no same-cycle bypass.
    assign lk_idx       = pc_i[IDX_W+1:2];
    assign lk_tag       = pc_i[PC_W-1:IDX_W+2];
    assign lk_entry     = table_q[lk_idx];
    assign lk_hit       = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign pred_taken_o = lk_hit && lk_entry.ctr[1];
    assign pred_pc_o    = pred_taken_o ? lk_entry.target : pc_i + PC_STEP;

    assign upd_idx   = upd_pc_i[IDX_W+1:2];
    assign upd_tag   = upd_pc_i[PC_W-1:IDX_W+2];
    assign upd_entry = table_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    sat_counter2 u_upd_ctr (
        .ctr_i      (upd_entry.ctr),
        .inc_i      (upd_taken_i),
        .ctr_next_c (upd_ctr_next)
    );

    // Table and performance counters; reset drops any simultaneous update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
            hit_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (lk_hit) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (upd_valid_i && upd_mispred_i) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            if (upd_valid_i) begin
                if (upd_hit) begin
                    table_q[upd_idx].ctr <= upd_ctr_next;
                    if (upd_taken_i) table_q[upd_idx].target <= upd_target_i;
                end else if (upd_taken_i) begin
                    table_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag,
                                          target: upd_target_i, ctr: CTR_WT};
                end
            end
        end
    end

    assign hit_cnt_o     = hit_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: behavioural BTB model
// checked every cycle, plus hand-computed literal expectations.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [31:0] hit_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int fails  = 0;

    branch_target_predictor dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_i          (pc),
        .pred_pc_o     (pred_pc),
        .pred_taken_o  (pred_taken),
        .upd_valid_i   (upd_valid),
        .upd_pc_i      (upd_pc),
        .upd_taken_i   (upd_taken),
        .upd_target_i  (upd_target),
        .upd_mispred_i (upd_mispred),
        .hit_cnt_o     (hit_cnt),
        .mispred_cnt_o (mispred_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid  [16];
    int unsigned m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    int unsigned m_hits;
    int unsigned m_mis;
    bit          m_ready = 0;

    function automatic int unsigned slot(input logic [31:0] a);
        return (a / 4) % 16;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_tag[slot(a)] == a / 64);
    endfunction

    function automatic bit m_taken(input logic [31:0] a);
        return m_hit(a) && (m_ctr[slot(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a);
        logic [32:0] sum;
        if (m_taken(a)) return m_target[slot(a)];
        sum = {1'b0, a} + 33'd4;
        return sum[31:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
            m_hits  = 0;
            m_mis   = 0;
            m_ready = 1;
        end else if (m_ready) begin
            int s;
            if (m_hit(pc)) m_hits++;
            if (upd_valid && upd_mispred) m_mis++;
            if (upd_valid) begin
                s = int'(slot(upd_pc));
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[s]    = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                        m_target[s] = upd_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[s]  = 1;
                    m_tag[s]    = upd_pc / 64;
                    m_target[s] = upd_target;
                    m_ctr[s]    = 2;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ready) begin
            checks++;
            if (pred_taken !== m_taken(pc)) begin
                fails++;
                $display("FAIL model_taken pc=%h got=%b exp=%b", pc, pred_taken, m_taken(pc));
            end
            checks++;
            if (pred_pc !== m_next(pc)) begin
                fails++;
                $display("FAIL model_pred_pc pc=%h got=%h exp=%h", pc, pred_pc, m_next(pc));
            end
            checks++;
            if (hit_cnt !== m_hits) begin
                fails++;
                $display("FAIL model_hit_cnt got=%0d exp=%0d", hit_cnt, m_hits);
            end
            checks++;
            if (mispred_cnt !== m_mis) begin
                fails++;
                $display("FAIL model_mispred_cnt got=%0d exp=%0d", mispred_cnt, m_mis);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] p, input logic uv, input logic [31:0] up,
                         input logic ut, input logic [31:0] tgt, input logic um,
                         input logic r);
        @(posedge clk);
        #1;
        pc = p; upd_valid = uv; upd_pc = up; upd_taken = ut;
        upd_target = tgt; upd_mispred = um; rst = r;
        #1;
    endtask

    task automatic look(input logic [31:0] p);
        drive(p, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] up, input logic ut, input logic [31:0] tgt);
        drive(32'h0000_1000, 1'b1, up, ut, tgt, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    logic [31:0] pcs [6] = '{32'h40, 32'h80, 32'h44, 32'hFFFF_FFFC, 32'h1000, 32'h7C};

    initial begin
        rst = 1'b1; pc = 32'h40; upd_valid = 0; upd_pc = 0;
        upd_taken = 0; upd_target = 0; upd_mispred = 0;
        repeat (2) @(posedge clk);

        // 1: reset state and PC wrap
        look(32'h40);
        chk("rst_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_pc", pred_pc, 32'h44);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_mis_cnt", mispred_cnt, 32'd0);
        look(32'hFFFF_FFFC);
        chk("wrap_pred_pc", pred_pc, 32'h0);

        // 2: allocate and hit
        upd(32'h40, 1'b1, 32'h100);
        look(32'h40);
        chk("alloc_taken", 32'(pred_taken), 32'd1);
        chk("alloc_pred_pc", pred_pc, 32'h100);
        look(32'h1000);
        chk("hit_cnt_one", hit_cnt, 32'd1);

        // 3: decrement to 00, low saturation, high saturation
        upd(32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("ctr00_pred_pc", pred_pc, 32'h44);
        upd(32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100);
        look(32'h40);
        chk("low_sat_taken", 32'(pred_taken), 32'd1);
        repeat (4) upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("high_sat_taken", 32'(pred_taken), 32'd1);
        chk("high_sat_pc", pred_pc, 32'h100);

        // 4: aliasing on index 0
        upd(32'h80, 1'b1, 32'h200);
        look(32'h40);
        chk("alias_old_pc", pred_pc, 32'h44);
        look(32'h80);
        chk("alias_new_pc", pred_pc, 32'h200);

        // 5: same-cycle lookup and update, no bypass
        upd(32'h40, 1'b1, 32'h100);
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 1'b0);
        chk("same_cycle_old", pred_pc, 32'h100);
        look(32'h40);
        chk("same_cycle_new", pred_pc, 32'h300);

        // mispredict counting; an invalid mispred flag is ignored
        drive(32'h1000, 1'b1, 32'h88, 1'b0, 32'h0, 1'b1, 1'b0);
        drive(32'h1000, 1'b0, 32'h88, 1'b1, 32'h0, 1'b1, 1'b0);
        drive(32'h1000, 1'b1, 32'h8C, 1'b1, 32'h500, 1'b1, 1'b0);
        look(32'h8C);
        chk("mis_cnt_two", mispred_cnt, 32'd2);
        chk("new_idx_pc", pred_pc, 32'h500);

        // mixed directed traffic, checked by the model
        for (int i = 0; i < 40; i++) begin
            drive(pcs[i % 6], 1'(i % 3 != 2), pcs[(i * 5 + 1) % 6], 1'(i % 4 != 3),
                  32'h1000 + 32'(i) * 32'h10, 1'(i % 5 == 0), 1'b0);
        end

        // 6: reset beats a simultaneous update
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h700, 1'b1, 1'b1);
        look(32'h40);
        chk("rst_upd_taken", 32'(pred_taken), 32'd0);
        chk("rst_upd_pc", pred_pc, 32'h44);
        chk("rst_upd_mis", mispred_cnt, 32'd0);
        chk("rst_upd_hit", hit_cnt, 32'd0);
        look(32'h80);
        chk("rst_upd_80", pred_pc, 32'h84);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
